// File: rtl/adc_pkt_buffer.sv
// adc_pkt_buffer: store-and-forward buffer between the ADC packetiser and the
// transmit path. Complete, length-consistent packets are committed to a byte
// RAM and replayed behind a two-byte sync header; bad packets are dropped.
module adc_pkt_buffer #(
    parameter int          P_ADDR_W      = 10,
    parameter int          P_PKT_DEPTH_W = 4,
    parameter logic [15:0] P_HEADER      = 16'h55AA
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [7:0]             i_adc_data,
    input  logic [7:0]             i_adc_len,
    input  logic                   i_adc_last,
    input  logic                   i_adc_valid,
    output logic [7:0]             o_data,
    output logic [7:0]             o_len,
    output logic                   o_last,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [15:0]            o_drop_cnt,
    output logic [P_PKT_DEPTH_W:0] o_pkt_pending
);
    localparam int RAM_DEPTH = 1 << P_ADDR_W;
    localparam int PKT_DEPTH = 1 << P_PKT_DEPTH_W;
    localparam logic [P_ADDR_W:0]      RAM_FULL = {1'b1, {P_ADDR_W{1'b0}}};
    localparam logic [P_ADDR_W:0]      PTR_ONE  = {{P_ADDR_W{1'b0}}, 1'b1};
    localparam logic [P_PKT_DEPTH_W:0] PKT_FULL = {1'b1, {P_PKT_DEPTH_W{1'b0}}};
    localparam logic [P_PKT_DEPTH_W:0] PKT_ONE  = {{P_PKT_DEPTH_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_HDR0, S_HDR1, S_PAY} state_e;

    logic [7:0]             ram      [RAM_DEPTH];
    logic [7:0]             len_fifo [PKT_DEPTH];

    logic [P_ADDR_W:0]      wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
    logic [P_ADDR_W:0]      rd_ptr_q, rd_ptr_d, used;
    logic [7:0]             exp_len_q, exp_len_d, byte_cnt_q, byte_cnt_d;
    logic [7:0]             cnt_eff, len_eff;
    logic                   ovf_q, ovf_d, in_pkt_q, in_pkt_d;
    logic                   first_byte, ovf_eff, wr_en, commit, drop;
    logic [15:0]            drop_cnt_q, drop_cnt_d;
    logic [P_PKT_DEPTH_W:0] lf_wr_q, lf_rd_q, lf_rd_d, pending_q, pending_d;
    logic                   lf_empty, slots_full, last_hs;
    state_e                 state_q, state_d;
    logic [7:0]             cur_len_q, cur_len_d, out_len_q, out_len_d;
    logic [7:0]             pay_cnt_q, pay_cnt_d, ram_rd_q;

    // Write side: absorb every valid byte, track overflow and decide commit/drop on last.
    // A packet slot stays owned until its last byte is sent, so the in-flight packet counts.
    always_comb begin
        first_byte = ~in_pkt_q;
        cnt_eff    = first_byte ? 8'd0 : byte_cnt_q;
        len_eff    = first_byte ? i_adc_len : exp_len_q;
        ovf_eff    = first_byte ? 1'b0 : ovf_q;
        used       = wr_ptr_q - rd_ptr_q;
        slots_full = (pending_q == PKT_FULL);
        wr_en      = i_adc_valid && (used != RAM_FULL) && (cnt_eff != 8'hFF);
        commit     = i_adc_valid && i_adc_last && wr_en && !ovf_eff && !slots_full
                     && (({1'b0, cnt_eff} + 9'd1) == {1'b0, len_eff});
        drop       = i_adc_valid && i_adc_last && !commit;

        in_pkt_d     = in_pkt_q;
        exp_len_d    = exp_len_q;
        byte_cnt_d   = byte_cnt_q;
        ovf_d        = ovf_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_cnt_d   = drop_cnt_q;

        if (i_adc_valid) begin
            in_pkt_d   = ~i_adc_last;
            exp_len_d  = len_eff;
            byte_cnt_d = wr_en ? (cnt_eff + 8'd1) : cnt_eff;
            ovf_d      = ovf_eff | ~wr_en;
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (commit) begin
            commit_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (drop) begin
            wr_ptr_d = commit_ptr_q;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    // Write-side registers and the length FIFO write pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            exp_len_q    <= '0;
            byte_cnt_q   <= '0;
            ovf_q        <= 1'b0;
            in_pkt_q     <= 1'b0;
            drop_cnt_q   <= '0;
            lf_wr_q      <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            exp_len_q    <= exp_len_d;
            byte_cnt_q   <= byte_cnt_d;
            ovf_q        <= ovf_d;
            in_pkt_q     <= in_pkt_d;
            drop_cnt_q   <= drop_cnt_d;
            if (commit) begin
                lf_wr_q <= lf_wr_q + PKT_ONE;
            end
        end
    end

    // Payload RAM and length FIFO storage; no reset so they map onto memory.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            ram[wr_ptr_q[P_ADDR_W-1:0]] <= i_adc_data;
        end
        if (commit) begin
            len_fifo[lf_wr_q[P_PKT_DEPTH_W-1:0]] <= len_eff;
        end
    end

    // Read FSM next state and outputs; RAM data is prefetched at the next read pointer.
    always_comb begin
        state_d   = state_q;
        cur_len_d = cur_len_q;
        out_len_d = out_len_q;
        pay_cnt_d = pay_cnt_q;
        rd_ptr_d  = rd_ptr_q;
        lf_rd_d   = lf_rd_q;
        lf_empty  = (lf_wr_q == lf_rd_q);
        o_valid   = 1'b0;
        o_data    = 8'd0;
        o_last    = 1'b0;
        last_hs   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!lf_empty) begin
                    cur_len_d = len_fifo[lf_rd_q[P_PKT_DEPTH_W-1:0]];
                    out_len_d = len_fifo[lf_rd_q[P_PKT_DEPTH_W-1:0]] + 8'd2;
                    lf_rd_d   = lf_rd_q + PKT_ONE;
                    state_d   = S_HDR0;
                end
            end
            S_HDR0: begin
                o_valid = 1'b1;
                o_data  = P_HEADER[15:8];
                if (i_ready) begin
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                o_valid = 1'b1;
                o_data  = P_HEADER[7:0];
                if (i_ready) begin
                    state_d   = S_PAY;
                    pay_cnt_d = 8'd1;
                end
            end
            S_PAY: begin
                o_valid = 1'b1;
                o_data  = ram_rd_q;
                o_last  = (pay_cnt_q == cur_len_q);
                if (i_ready) begin
                    rd_ptr_d  = rd_ptr_q + PTR_ONE;
                    pay_cnt_d = pay_cnt_q + 8'd1;
                    if (o_last) begin
                        last_hs = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        pending_d = pending_q;
        if (commit && !last_hs) begin
            pending_d = pending_q + PKT_ONE;
        end else if (!commit && last_hs) begin
            pending_d = pending_q - PKT_ONE;
        end
    end

    // Read-side registers, including the one-cycle-latency RAM read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cur_len_q <= '0;
            out_len_q <= '0;
            pay_cnt_q <= '0;
            rd_ptr_q  <= '0;
            lf_rd_q   <= '0;
            pending_q <= '0;
            ram_rd_q  <= '0;
        end else begin
            state_q   <= state_d;
            cur_len_q <= cur_len_d;
            out_len_q <= out_len_d;
            pay_cnt_q <= pay_cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            lf_rd_q   <= lf_rd_d;
            pending_q <= pending_d;
            ram_rd_q  <= ram[rd_ptr_d[P_ADDR_W-1:0]];
        end
    end

    assign o_len         = out_len_q;
    assign o_drop_cnt    = drop_cnt_q;
    assign o_pkt_pending = pending_q;

endmodule
